// File: rtl/uart_fifo_core.sv
// UART front end with configurable frame format, RX/TX FIFOs on valid/ready streams,
// RX framing/parity/overrun flags and an optional idle gap after each TX frame.
module uart_fifo_core #(
  parameter int CLK_DIV    = 234,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int TX_GAP     = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          uart_rx,
  output logic                          uart_tx,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_perr,
  output logic                          rx_ferr,
  output logic                          rx_overrun,
  input  logic                          clear_err,
  output logic [$clog2(FIFO_DEPTH):0]   tx_count,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int GW = $clog2(TX_GAP + 2);
  localparam int EW = DATA_BITS + 2;
  localparam logic [AW:0]    FULL      = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]  DIV       = CW'(CLK_DIV);
  localparam logic [CW-1:0]  HALF      = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0]  TMR_ONE   = CW'(1);
  localparam logic [BW-1:0]  LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0]  LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic [GW-1:0]  GAP_END   = GW'(TX_GAP);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP, TX_GAP_S} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_e;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]        tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [AW:0]          tx_fill_q, tx_fill_d;
  logic                 tx_push, tx_pop;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_head = tx_mem[tx_rp_q];

  always_comb begin
    tx_ready  = (tx_fill_q != FULL);
    tx_push   = tx_valid && tx_ready;
    tx_wp_d   = tx_wp_q + AW'(tx_push);
    tx_rp_d   = tx_rp_q + AW'(tx_pop);
    tx_fill_d = tx_fill_q;
    if (tx_push && !tx_pop)      tx_fill_d = tx_fill_q + (AW+1)'(1);
    else if (!tx_push && tx_pop) tx_fill_d = tx_fill_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q] <= tx_data;
  end

  // ---------------- RX FIFO ----------------
  logic [EW-1:0]   rx_mem [FIFO_DEPTH];
  logic [AW-1:0]   rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [AW:0]     rx_fill_q, rx_fill_d;
  logic            rx_wr, rx_push, rx_pop;
  logic [EW-1:0]   rx_wdata;
  logic            rx_ovr_q, rx_ovr_d;

  assign {rx_data, rx_perr, rx_ferr} = rx_mem[rx_rp_q];

  // A full FIFO still accepts the frame when the consumer pops in the same cycle.
  always_comb begin
    rx_valid  = (rx_fill_q != '0);
    rx_pop    = rx_valid && rx_ready;
    rx_push   = rx_wr && ((rx_fill_q != FULL) || rx_pop);
    rx_wp_d   = rx_wp_q + AW'(rx_push);
    rx_rp_d   = rx_rp_q + AW'(rx_pop);
    rx_fill_d = rx_fill_q;
    if (rx_push && !rx_pop)      rx_fill_d = rx_fill_q + (AW+1)'(1);
    else if (!rx_push && rx_pop) rx_fill_d = rx_fill_q - (AW+1)'(1);
    rx_ovr_d = rx_ovr_q;
    if (rx_wr && !rx_push) rx_ovr_d = 1'b1;
    else if (clear_err)    rx_ovr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp_q] <= rx_wdata;
  end

  // ---------------- TX shifter ----------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_tmr_q, tx_tmr_d;
  logic [BW-1:0]        tx_idx_q, tx_idx_d;
  logic [GW-1:0]        tx_gap_q, tx_gap_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_line_q, tx_line_d;
  logic                 tx_load;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tmr_d   = tx_tmr_q + TMR_ONE;
    tx_idx_d   = tx_idx_q;
    tx_gap_d   = tx_gap_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_line_d  = tx_line_q;
    tx_pop     = 1'b0;
    tx_load    = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: tx_load = 1'b1;
      TX_START: if (tx_tmr_q == DIV) begin
        tx_state_d = TX_DATA;
        tx_tmr_d   = TMR_ONE;
        tx_idx_d   = '0;
        tx_line_d  = tx_shift_q[0];
      end
      TX_DATA: if (tx_tmr_q == DIV) begin
        tx_tmr_d = TMR_ONE;
        if (tx_idx_q == LAST_BIT) begin
          tx_idx_d = '0;
          if (PARITY != 0) begin
            tx_state_d = TX_PAR;
            tx_line_d  = tx_par_q;
          end else begin
            tx_state_d = TX_STOP;
            tx_line_d  = 1'b1;
          end
        end else begin
          tx_idx_d   = tx_idx_q + BW'(1);
          tx_shift_d = tx_shift_q >> 1;
          tx_line_d  = tx_shift_q[1];
        end
      end
      TX_PAR: if (tx_tmr_q == DIV) begin
        tx_state_d = TX_STOP;
        tx_tmr_d   = TMR_ONE;
        tx_idx_d   = '0;
        tx_line_d  = 1'b1;
      end
      TX_STOP: if (tx_tmr_q == DIV) begin
        tx_tmr_d = TMR_ONE;
        if (tx_idx_q != LAST_STOP) tx_idx_d = tx_idx_q + BW'(1);
        else if (TX_GAP > 0) begin
          tx_state_d = TX_GAP_S;
          tx_gap_d   = GW'(1);
        end else tx_load = 1'b1;
      end
      TX_GAP_S: begin
        if (tx_gap_q == GAP_END) tx_load = 1'b1;
        else tx_gap_d = tx_gap_q + GW'(1);
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Frame end and idle share one reload path so queued frames go out back to back.
    if (tx_load) begin
      if (tx_fill_q != '0) begin
        tx_pop     = 1'b1;
        tx_state_d = TX_START;
        tx_tmr_d   = TMR_ONE;
        tx_shift_d = tx_head;
        tx_par_d   = (^tx_head) ^ (PARITY == 2);
        tx_line_d  = 1'b0;
      end else begin
        tx_state_d = TX_IDLE;
        tx_line_d  = 1'b1;
      end
    end
  end

  assign uart_tx  = tx_line_q;
  assign tx_busy  = (tx_state_q != TX_IDLE);
  assign tx_count = tx_fill_q;
  assign rx_count = rx_fill_q;
  assign rx_overrun = rx_ovr_q;

  // ---------------- RX deserialiser ----------------
  rx_state_e            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_tmr_q, rx_tmr_d;
  logic [BW-1:0]        rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_s1_q, rx_s2_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tmr_d   = rx_tmr_q + TMR_ONE;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_perr_d  = rx_perr_q;
    rx_wr      = 1'b0;
    rx_wdata   = {rx_shift_q, rx_perr_q, ~rx_s2_q};
    unique case (rx_state_q)
      RX_IDLE: if (!rx_s2_q) begin
        rx_state_d = RX_START;
        rx_tmr_d   = TMR_ONE;
        rx_perr_d  = 1'b0;
      end
      RX_START: if (rx_tmr_q == HALF) begin
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        rx_tmr_d   = TMR_ONE;
        rx_idx_d   = '0;
      end
      RX_DATA: if (rx_tmr_q == DIV) begin
        rx_tmr_d   = TMR_ONE;
        rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
        if (rx_idx_q == LAST_BIT) rx_state_d = (PARITY != 0) ? RX_PAR : RX_STOP;
        else rx_idx_d = rx_idx_q + BW'(1);
      end
      RX_PAR: if (rx_tmr_q == DIV) begin
        rx_tmr_d   = TMR_ONE;
        rx_perr_d  = rx_s2_q ^ (^rx_shift_q) ^ (PARITY == 2);
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_tmr_q == DIV) begin
        rx_wr      = 1'b1;
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_fill_q  <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_fill_q  <= '0;
      rx_ovr_q   <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_tmr_q   <= '0;
      tx_idx_q   <= '0;
      tx_gap_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_tmr_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_perr_q  <= 1'b0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
    end else begin
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      tx_fill_q  <= tx_fill_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      rx_fill_q  <= rx_fill_d;
      rx_ovr_q   <= rx_ovr_d;
      tx_state_q <= tx_state_d;
      tx_tmr_q   <= tx_tmr_d;
      tx_idx_q   <= tx_idx_d;
      tx_gap_q   <= tx_gap_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_line_q  <= tx_line_d;
      rx_state_q <= rx_state_d;
      rx_tmr_q   <= rx_tmr_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_perr_q  <= rx_perr_d;
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
    end
  end

endmodule
